oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have parameter DMA_REGISTER_ADDRESS, default 16'h4014: CPU write address that triggers a transfer.
REQ-002 The block SHALL have parameter OAM_DATA_ADDRESS, default 16'h2004: destination address of every DMA write.
REQ-003 The block SHALL have port clock_i  input  1  system clock; one clock, all state on its rising edge.
REQ-004 The block SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port tick_i  input  1  CPU-cycle enable pulse; all state changes only on clock edges where tick_i=1.
REQ-006 The block SHALL have port cpu_address_i  input  16  CPU bus address.
REQ-007 The block SHALL have port cpu_data_i  input  8  CPU write data.
REQ-008 The block SHALL have port cpu_write_i  input  1  CPU write strobe.
REQ-009 The block SHALL have port bus_data_i  input  8  read data from the shared bus.
REQ-010 The block SHALL have port bus_data_valid_i  input  1  bus_data_i valid this cycle.
REQ-011 The block SHALL have port cpu_halt_o  output  1  stalls CPU; CPU holds all state while high.
REQ-012 The block SHALL have port bus_grant_o  output  1  DMA owns the shared bus; selects the DMA bus outputs in the bus mux.
REQ-013 The block SHALL have port bus_address_o  output  16  DMA bus address.
REQ-014 The block SHALL have port bus_data_o  output  8  DMA write data.
REQ-015 The block SHALL have port bus_read_o  output  1  DMA read request.
REQ-016 The block SHALL have port bus_write_o  output  1  DMA write strobe.
REQ-017 The block SHALL have port busy_o  output  1  high in every state other than IDLE.

Function
REQ-018 States SHALL be IDLE, HALT, ALIGN, READ, WRITE. Registers: page (8b), index (8b), latch (8b), parity (1b).
REQ-019 parity SHALL toggle on every tick in every state; the current cycle is even when parity=0.
REQ-020 IDLE: a tick with cpu_write_i=1 and cpu_address_i=DMA_REGISTER_ADDRESS SHALL latch page<=cpu_data_i, set index<=0 and go to HALT.
REQ-021 HALT: the next tick SHALL go to ALIGN if parity=0 on that tick, else to READ.
REQ-022 ALIGN: the next tick SHALL go to READ. READ therefore always begins on an even cycle.
REQ-023 READ: on a tick with bus_data_valid_i=1, the block SHALL set latch<=bus_data_i and go to WRITE; with bus_data_valid_i=0 it SHALL stay in READ with no parity re-alignment.
REQ-024 WRITE: on the next tick the block SHALL set index<=index+1 (8-bit wrap); if index=255 it SHALL go to IDLE, else to READ.
REQ-025 Outputs SHALL be Moore, a function of registered state only, with no combinational path from inputs.
  - IDLE: all outputs 0.
  - HALT, ALIGN: cpu_halt_o=1, bus_grant_o=1, busy_o=1; address, data, read and write 0.
  - READ: bus_address_o={page,index}, bus_read_o=1, bus_data_o=0, plus halt, grant and busy.
  - WRITE: bus_address_o=OAM_DATA_ADDRESS, bus_data_o=latch, bus_write_o=1, plus halt, grant and busy.
REQ-026 A write to DMA_REGISTER_ADDRESS while not IDLE SHALL be ignored; the in-flight page SHALL be unchanged.
REQ-027 A trigger write SHALL be accepted on the same tick that the FSM returns to IDLE only if the FSM is already in IDLE on that tick; there is no queuing.
REQ-028 Halted duration with no read stalls SHALL be 513 ticks if triggered on an even cycle and 514 ticks if triggered on an odd cycle, with 256 reads and 256 writes.
REQ-029 Page 8'hFF SHALL read 16'hFF00 to 16'hFFFF; index wrap SHALL never carry into page.

Reset
REQ-030 While reset_i=1 at a clock edge, regardless of tick_i, the block SHALL set state=IDLE, page=0, index=0, latch=0 and parity=0.
REQ-031 After reset, all outputs SHALL be 0.
REQ-032 Reset mid-transfer SHALL abort the transfer immediately; cpu_halt_o and bus_grant_o SHALL be 0 after that edge, and no partial state SHALL resume.

Verification
REQ-033 Trigger write 8'h02 to 16'h4014 on an even tick, memory[16'h0200+i]=i, valid always 1 -> 513 halted ticks; writes to 16'h2004 carry 8'h00 to 8'hFF in order.
REQ-034 Same transfer triggered on an odd tick -> exactly one ALIGN tick and 514 halted ticks; first read at 16'h0200 on an even tick.
REQ-035 Page 8'hFF, memory[16'hFFxx]=~xx -> last read at 16'hFFFF, last written byte 8'h00, then IDLE with all outputs 0.
REQ-036 Hold bus_data_valid_i=0 for 3 ticks on the read of index 5 -> READ held 3 extra ticks, data still correct, total halted ticks +3.
REQ-037 Second write 8'h07 to 16'h4014 at index 100 -> ignored; reads stay in the original page through index 255.
REQ-038 Assert reset_i at index 40 -> next edge gives IDLE with cpu_halt_o=0 and bus_grant_o=0; a new trigger runs a full 256-byte transfer from index 0.

Source files
------------

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma: sprite-attribute DMA engine.
// A CPU write to DMA_REGISTER_ADDRESS starts a transfer. The engine then
// stalls the CPU and copies the 256 bytes {page, 8'h00}..{page, 8'hFF} to
// OAM_DATA_ADDRESS, using one read and one write per byte. READ always
// begins on an even CPU cycle, so a trigger on an odd cycle costs one extra
// ALIGN cycle.
//
// Ports
//   clock_i          system clock; all state changes on its rising edge
//   reset_i          synchronous active-high reset
//   tick_i           CPU-cycle enable; state only advances when high
//   cpu_address_i    CPU bus address (watched for the trigger write)
//   cpu_data_i       CPU write data (becomes the source page)
//   cpu_write_i      CPU write strobe
//   bus_data_i       read data returned by the shared bus
//   bus_data_valid_i bus_data_i is valid this cycle
//   cpu_halt_o       stalls the CPU while the engine is active
//   bus_grant_o      the engine owns the shared bus
//   bus_address_o    engine bus address
//   bus_data_o       engine write data
//   bus_read_o       engine read request
//   bus_write_o      engine write strobe
//   busy_o           high in every state except IDLE
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] DMA_REGISTER_ADDRESS = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDRESS     = 16'h2004
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic [15:0] cpu_address_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_write_i,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_data_valid_i,
  output logic        cpu_halt_o,
  output logic        bus_grant_o,
  output logic [15:0] bus_address_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  latch_q, latch_d;
  logic        parity_q, parity_d;

  // Output registers; they hold the decode of the state being entered, so
  // they always equal a pure function of the current registered state.
  logic        cpu_halt_q, cpu_halt_d;
  logic        bus_grant_q, bus_grant_d;
  logic [15:0] bus_address_q, bus_address_d;
  logic [7:0]  bus_data_q, bus_data_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic        busy_q, busy_d;

  logic        trigger_s;

  assign trigger_s = cpu_write_i && (cpu_address_i == DMA_REGISTER_ADDRESS);

  // Next-state logic: transfer sequencing, gated by the CPU-cycle tick.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    latch_d  = latch_q;
    parity_d = parity_q;
    if (tick_i) begin
      // parity_q is the parity of the cycle ending at this tick (0 = even)
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if (trigger_s) begin
            page_d  = cpu_data_i;
            index_d = 8'd0;
            state_d = ST_HALT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          // Leaving HALT on an even tick would start READ on an odd cycle.
          if (parity_q == 1'b0) begin
            state_d = ST_ALIGN;
          end else begin
            state_d = ST_READ;
          end
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          if (bus_data_valid_i) begin
            latch_d = bus_data_i;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
        ST_WRITE: begin
          // index wraps inside 8 bits; page is never touched here
          index_d = index_q + 8'd1;
          if (index_q == 8'hFF) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode of the state being entered next edge.
  always_comb begin
    cpu_halt_d    = 1'b0;
    bus_grant_d   = 1'b0;
    bus_address_d = 16'h0000;
    bus_data_d    = 8'h00;
    bus_read_d    = 1'b0;
    bus_write_d   = 1'b0;
    busy_d        = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_HALT, ST_ALIGN: begin
        cpu_halt_d  = 1'b1;
        bus_grant_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_READ: begin
        cpu_halt_d    = 1'b1;
        bus_grant_d   = 1'b1;
        busy_d        = 1'b1;
        bus_address_d = {page_d, index_d};
        bus_read_d    = 1'b1;
      end
      ST_WRITE: begin
        cpu_halt_d    = 1'b1;
        bus_grant_d   = 1'b1;
        busy_d        = 1'b1;
        bus_address_d = OAM_DATA_ADDRESS;
        bus_data_d    = latch_d;
        bus_write_d   = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      page_q        <= 8'h00;
      index_q       <= 8'h00;
      latch_q       <= 8'h00;
      parity_q      <= 1'b0;
      cpu_halt_q    <= 1'b0;
      bus_grant_q   <= 1'b0;
      bus_address_q <= 16'h0000;
      bus_data_q    <= 8'h00;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      page_q        <= page_d;
      index_q       <= index_d;
      latch_q       <= latch_d;
      parity_q      <= parity_d;
      cpu_halt_q    <= cpu_halt_d;
      bus_grant_q   <= bus_grant_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      busy_q        <= busy_d;
    end
  end

  assign cpu_halt_o    = cpu_halt_q;
  assign bus_grant_o   = bus_grant_q;
  assign bus_address_o = bus_address_q;
  assign bus_data_o    = bus_data_q;
  assign bus_read_o    = bus_read_q;
  assign bus_write_o   = bus_write_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma: scoreboard bench for oam_dma. Stimulus pushes the expected
// read addresses and written bytes of each transfer into queues; a monitor
// pops and compares whenever the DUT presents a bus read (with valid data)
// or a bus write, and counts halted / pre-read ticks per transfer.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        tick_i;
  logic [15:0] cpu_address_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_write_i;
  logic [7:0]  bus_data_i;
  logic        bus_data_valid_i;
  logic        cpu_halt_o;
  logic        bus_grant_o;
  logic [15:0] bus_address_o;
  logic [7:0]  bus_data_o;
  logic        bus_read_o;
  logic        bus_write_o;
  logic        busy_o;

  always #5 clk = ~clk;

  oam_dma dut (
    .clock_i          (clk),
    .reset_i          (reset_i),
    .tick_i           (tick_i),
    .cpu_address_i    (cpu_address_i),
    .cpu_data_i       (cpu_data_i),
    .cpu_write_i      (cpu_write_i),
    .bus_data_i       (bus_data_i),
    .bus_data_valid_i (bus_data_valid_i),
    .cpu_halt_o       (cpu_halt_o),
    .bus_grant_o      (bus_grant_o),
    .bus_address_o    (bus_address_o),
    .bus_data_o       (bus_data_o),
    .bus_read_o       (bus_read_o),
    .bus_write_o      (bus_write_o),
    .busy_o           (busy_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_wr_q[$];
  int          halt_cnt = 0;
  int          pre_cnt = 0;
  logic        rd_seen = 1'b0;
  logic        first_rd_par = 1'b1;
  logic        tb_par = 1'b0;
  logic        stall_req = 1'b0;
  int          stall_used = 0;

  // Memory image: page 02 -> low byte, page FF -> inverted low byte,
  // page 07 -> low byte ^ 5A, anything else -> low byte ^ page.
  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a[15:8])
      8'h02:   mem = lo;
      8'hFF:   mem = ~lo;
      8'h07:   mem = lo ^ 8'h5A;
      default: mem = lo ^ a[15:8];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder; optionally withholds valid for 3 ticks on index 5.
  always_comb begin
    bus_data_i       = mem(bus_address_o);
    bus_data_valid_i = bus_read_o &&
                       !(stall_req && (stall_used < 3) && (bus_address_o[7:0] == 8'd5));
  end

  always @(posedge clk) begin
    if (!reset_i && tick_i && bus_read_o && stall_req && (stall_used < 3) &&
        (bus_address_o[7:0] == 8'd5))
      stall_used <= stall_used + 1;
  end

  // Reference cycle parity: toggles on every tick, cleared by reset.
  always @(posedge clk) begin
    if (reset_i) tb_par <= 1'b0;
    else if (tick_i) tb_par <= ~tb_par;
  end

  // Monitor: compares bus traffic against the scoreboard at mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!reset_i && tick_i) begin
      if (cpu_write_i && (cpu_address_i == 16'h4014) && !busy_o) begin
        halt_cnt = 0;
        pre_cnt  = 0;
        rd_seen  = 1'b0;
      end
      if (cpu_halt_o) halt_cnt++;
      if (cpu_halt_o && !bus_read_o && !bus_write_o) begin
        pre_cnt++;
        check("pre_read_addr", {16'h0, bus_address_o}, 32'h0);
      end
      if (bus_read_o) begin
        if (!rd_seen) begin
          rd_seen      = 1'b1;
          first_rd_par = tb_par;
        end
        if (bus_data_valid_i) begin
          check("rd_expected", {31'h0, exp_rd_q.size() != 0}, 32'h1);
          if (exp_rd_q.size() != 0)
            check("rd_addr", {16'h0, bus_address_o}, {16'h0, exp_rd_q.pop_front()});
          check("rd_data_out", {24'h0, bus_data_o}, 32'h0);
        end
      end
      if (bus_write_o) begin
        check("wr_expected", {31'h0, exp_wr_q.size() != 0}, 32'h1);
        if (exp_wr_q.size() != 0)
          check("wr_data", {24'h0, bus_data_o}, {24'h0, exp_wr_q.pop_front()});
        check("wr_addr", {16'h0, bus_address_o}, 32'h2004);
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {cpu_halt_o, bus_grant_o, busy_o, bus_read_o, bus_write_o,
                 bus_address_o, bus_data_o}, 32'h0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_address_i = a;
    cpu_data_i    = d;
    cpu_write_i   = 1'b1;
    @(posedge clk); #1;
    cpu_write_i   = 1'b0;
    cpu_address_i = 16'h0000;
  endtask

  // Queue expectations for a whole page, then trigger on the wanted parity.
  task automatic start_xfer(input logic [7:0] page, input logic want_par);
    for (int i = 0; i < 256; i++) begin
      exp_rd_q.push_back({page, i[7:0]});
      exp_wr_q.push_back(mem({page, i[7:0]}));
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (tb_par == want_par) break;
    end
    cpu_write(16'h4014, page);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'h0, done}, 32'h1);
  endtask

  task automatic finish_xfer(input string name, input int exp_halt, input int exp_pre);
    wait_idle({name, "_idle"});
    check({name, "_halt_ticks"}, halt_cnt, exp_halt);
    check({name, "_pre_ticks"}, pre_cnt, exp_pre);
    check({name, "_first_rd_even"}, {31'h0, first_rd_par}, 32'h0);
    check({name, "_rd_left"}, exp_rd_q.size(), 32'h0);
    check({name, "_wr_left"}, exp_wr_q.size(), 32'h0);
    check_all_zero({name, "_outputs_idle"});
  endtask

  task automatic wait_read_index(input logic [7:0] idx);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus_read_o && (bus_address_o[7:0] == idx)) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_read_index", {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i       = 1'b1;
    tick_i        = 1'b1;
    cpu_write_i   = 1'b0;
    cpu_address_i = 16'h0000;
    cpu_data_i    = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");

    // Trigger without a tick, and a write to a neighbouring address: ignored.
    @(posedge clk); #1;
    tick_i = 1'b0;
    cpu_write(16'h4014, 8'h33);
    tick_i = 1'b1;
    @(negedge clk);
    check("no_tick_no_start", {31'h0, busy_o}, 32'h0);
    @(posedge clk); #1;
    cpu_write(16'h4015, 8'h02);
    @(negedge clk);
    check("wrong_addr_no_start", {31'h0, busy_o}, 32'h0);

    // Even trigger: 513 halted ticks, no ALIGN.
    start_xfer(8'h02, 1'b0);
    finish_xfer("even", 513, 1);

    // Odd trigger: one ALIGN tick, 514 halted ticks.
    start_xfer(8'h02, 1'b1);
    finish_xfer("odd", 514, 2);

    // Top page, inverted data.
    start_xfer(8'hFF, 1'b0);
    finish_xfer("page_ff", 513, 1);

    // Three-tick stall on the read of index 5.
    stall_req = 1'b1;
    start_xfer(8'h02, 1'b0);
    finish_xfer("stall", 516, 1);
    check("stall_ticks_used", stall_used, 3);

    // Retrigger with page 07 at index 100 must be ignored.
    start_xfer(8'h02, 1'b1);
    wait_read_index(8'd100);
    @(posedge clk); #1;
    cpu_write(16'h4014, 8'h07);
    finish_xfer("retrigger", 514, 2);

    // Reset at index 40 aborts; a fresh trigger does a full transfer.
    start_xfer(8'h02, 1'b0);
    wait_read_index(8'd40);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    check("abort_halt", {31'h0, cpu_halt_o}, 32'h0);
    check("abort_grant", {31'h0, bus_grant_o}, 32'h0);
    check_all_zero("abort_outputs");
    repeat (3) @(negedge clk);
    check("abort_stays_idle", {31'h0, busy_o}, 32'h0);
    start_xfer(8'h10, 1'b0);
    finish_xfer("after_reset", 513, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
